// File: rtl/lcd_seq_pkg.sv
// lcd_seq_pkg: shared types, init ROM and timing-count helpers for the PmodCLP bus sequencer.
package lcd_seq_pkg;
  localparam int TIMER_W = 22;
  localparam int INIT_LEN = 4;
  typedef enum logic [2:0] {PWRUP, IDLE, SETUP, E_HIGH, HOLD, EXEC} state_t;
  typedef enum logic [2:0] {TM_SU, TM_EH, TM_H, TM_SHORT, TM_LONG, TM_PWR} timing_t;
  // Entry 0 in the low byte: function set, display on, clear, entry mode.
  localparam logic [INIT_LEN*8-1:0] INIT_ROM = {8'h06, 8'h01, 8'h0C, 8'h38};
  localparam logic [7:0] CMD_LONG_LO = 8'h01;
  localparam logic [7:0] CMD_LONG_HI = 8'h03;
  function automatic logic [TIMER_W-1:0] ns_to_cycles(int unsigned ns, int unsigned hz);
    logic [63:0] p;
    p = 64'(ns) * 64'(hz);
    return TIMER_W'((p + 64'd999_999_999) / 64'd1_000_000_000);
  endfunction
  function automatic logic [TIMER_W-1:0] timing_count(timing_t sel, int unsigned hz, bit sim);
    return sel == TM_SU    ? ns_to_cycles(40, hz) :
           sel == TM_EH    ? ns_to_cycles(250, hz) :
           sel == TM_H     ? ns_to_cycles(20, hz) :
           sel == TM_SHORT ? (sim ? TIMER_W'(40) : ns_to_cycles(40_000, hz)) :
           sel == TM_LONG  ? (sim ? TIMER_W'(200) : ns_to_cycles(1_640_000, hz)) :
                             (sim ? TIMER_W'(1000) : ns_to_cycles(30_000_000, hz));
  endfunction
  function automatic logic [7:0] init_byte(logic [1:0] idx);
    return INIT_ROM[{idx, 3'b000} +: 8];
  endfunction
  function automatic logic is_long_cmd(logic rs, logic [7:0] d);
    return !rs && d >= CMD_LONG_LO && d <= CMD_LONG_HI;
  endfunction
endpackage

// File: rtl/lcd_delay_timer.sv
// lcd_delay_timer: loadable down-counter; done while the count sits at zero.
module lcd_delay_timer
  import lcd_seq_pkg::*;
#(
  parameter logic [TIMER_W-1:0] RST_VALUE = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_value,
  output logic               done
);
  logic [TIMER_W-1:0] count;
  assign done = count == '0;
  always_ff @(posedge clk or negedge reset)
    if (!reset) count <= RST_VALUE;
    else count <= load ? load_value : done ? count : count - 1'b1;
endmodule

// File: rtl/lcd_bus_sequencer.sv
// lcd_bus_sequencer: owns the PmodCLP bus, runs LCD power-up init, then serves single-byte writes.
module lcd_bus_sequencer
  import lcd_seq_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 100000000,
  parameter int unsigned SIMULATE    = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  input  logic       req_rs,
  input  logic [7:0] req_data,
  output logic       req_ready,
  output logic       busy,
  output logic       init_done,
  output logic       PmodCLP_RS,
  output logic       PmodCLP_RW,
  output logic       PmodCLP_E,
  output logic [7:0] PmodCLP_DataBus
);
  localparam bit SIM = SIMULATE != 0;
  // Timer loads are count-1 so each state lasts exactly its count in cycles.
  localparam logic [TIMER_W-1:0] L_SU = timing_count(TM_SU, CLK_FREQ_HZ, SIM) - TIMER_W'(1);
  localparam logic [TIMER_W-1:0] L_EH = timing_count(TM_EH, CLK_FREQ_HZ, SIM) - TIMER_W'(1);
  localparam logic [TIMER_W-1:0] L_H = timing_count(TM_H, CLK_FREQ_HZ, SIM) - TIMER_W'(1);
  localparam logic [TIMER_W-1:0] L_SHORT = timing_count(TM_SHORT, CLK_FREQ_HZ, SIM) - TIMER_W'(1);
  localparam logic [TIMER_W-1:0] L_LONG = timing_count(TM_LONG, CLK_FREQ_HZ, SIM) - TIMER_W'(1);
  localparam logic [TIMER_W-1:0] L_PWR = timing_count(TM_PWR, CLK_FREQ_HZ, SIM) - TIMER_W'(1);
  state_t             state;
  logic [1:0]         idx;
  logic               long_q;
  logic               t_load;
  logic               t_done;
  logic [TIMER_W-1:0] t_value;
  logic               exec_fin;
  logic               next_init;
  logic               accept;
  logic               issue;
  logic               issue_rs;
  logic [7:0]         issue_data;
  assign exec_fin   = state == EXEC && t_done;
  assign next_init  = exec_fin && !init_done && idx != 2'(INIT_LEN - 1);
  // Ready in the final EXEC cycle lets a held request go out with no idle gap.
  assign req_ready  = state == IDLE || (exec_fin && !next_init);
  assign busy       = !req_ready;
  assign accept     = req_valid && req_ready;
  assign issue      = accept || next_init || (state == PWRUP && t_done);
  assign issue_rs   = accept ? req_rs : 1'b0;
  assign issue_data = accept ? req_data : init_byte(next_init ? idx + 2'd1 : 2'd0);
  assign PmodCLP_RW = 1'b0;
  assign t_load     = issue || (t_done && (state == SETUP || state == E_HIGH || state == HOLD));
  assign t_value    = issue ? L_SU : state == SETUP ? L_EH : state == E_HIGH ? L_H : long_q ? L_LONG : L_SHORT;
  lcd_delay_timer #(
    .RST_VALUE(L_PWR)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (t_load),
    .load_value(t_value),
    .done      (t_done)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state           <= PWRUP;
      idx             <= '0;
      long_q          <= 1'b0;
      init_done       <= 1'b0;
      PmodCLP_RS      <= 1'b0;
      PmodCLP_E       <= 1'b0;
      PmodCLP_DataBus <= '0;
    end else begin
      if (issue) begin
        state           <= SETUP;
        PmodCLP_RS      <= issue_rs;
        PmodCLP_DataBus <= issue_data;
        long_q          <= is_long_cmd(issue_rs, issue_data);
      end else if (t_done) begin
        state <= state == SETUP ? E_HIGH : state == E_HIGH ? HOLD : state == HOLD ? EXEC :
                 state == EXEC ? IDLE : state;
      end
      if (t_done) PmodCLP_E <= state == SETUP;
      if (next_init) idx <= idx + 2'd1;
      if (exec_fin && !next_init) init_done <= 1'b1;
    end
endmodule

// File: tb/tb_lcd_bus_sequencer.sv
// tb_lcd_bus_sequencer: directed, table-driven checks of init, write timing, throughput and reset abort.
module tb_lcd_bus_sequencer;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_rs = 1'b0;
  logic [7:0] req_data = 8'h00;
  logic       req_ready, busy, init_done, rs, rw, e;
  logic [7:0] db;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  logic       prev_e = 1'b0;
  int         w_cnt = 0;
  int         e_rise = -1;
  int         e_fall = -1;
  logic [7:0] p_data[$];
  logic       p_rs[$];
  int         p_w[$];

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         gap;
  } vec_t;
  vec_t vecs[7];

  lcd_bus_sequencer #(.CLK_FREQ_HZ(100000000), .SIMULATE(1)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_rs         (req_rs),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .busy           (busy),
    .init_done      (init_done),
    .PmodCLP_RS     (rs),
    .PmodCLP_RW     (rw),
    .PmodCLP_E      (e),
    .PmodCLP_DataBus(db)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (e && !prev_e) begin
      e_rise = cyc;
      w_cnt = 0;
    end
    if (e) w_cnt++;
    if (prev_e && !e) begin
      e_fall = cyc;
      p_data.push_back(db);
      p_rs.push_back(rs);
      p_w.push_back(w_cnt);
    end
    prev_e = e;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  task automatic clear_pulses();
    p_data.delete();
    p_rs.delete();
    p_w.delete();
  endtask

  task automatic wait_rdy(input string name, output int edge_no);
    int n = 0;
    while (!req_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk({name, "_timeout"}, 0, 1);
    edge_no = cyc + 1;
  endtask

  task automatic send(input logic r, input logic [7:0] d, output int acc);
    req_valid = 1'b1;
    req_rs = r;
    req_data = d;
    wait_rdy("accept", acc);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic do_init(input bit hold);
    int c0, rdy, dn, n, r;
    clear_pulses();
    rdy = -1;
    dn = -1;
    n = 0;
    reset = 1'b1;
    c0 = cyc;
    while (dn < 0 && n < 3000) begin
      @(negedge clk);
      n++;
      if (req_ready && rdy < 0) rdy = cyc + 1 - c0;
      if (init_done && dn < 0) dn = cyc - c0;
    end
    chk("init_ready_edge", rdy, 1444);
    chk("init_done_cycle", dn, 1444);
    chk("init_pulse_count", p_data.size(), hold ? 4 : 4);
    for (int i = 0; i < 4 && i < p_data.size(); i++) begin
      chk($sformatf("init_data_%0d", i), p_data[i], i == 0 ? 8'h38 : i == 1 ? 8'h0C : i == 2 ? 8'h01 : 8'h06);
      chk($sformatf("init_rs_%0d", i), p_rs[i], 0);
      chk($sformatf("init_width_%0d", i), p_w[i], 25);
    end
    if (hold) begin
      chk("held_req_rs", rs, 1);
      chk("held_req_data", db, 8'h55);
      req_valid = 1'b0;
      wait_rdy("held_req", r);
      chk("held_req_gap", r - (c0 + 1444), 71);
      chk("held_req_pulses", p_data.size(), 5);
      if (p_data.size() == 5) chk("held_req_pulse_data", p_data[4], 8'h55);
    end
  endtask

  initial begin
    int acc, r, a1, a2, a3, bad;
    vecs[0] = '{rs: 1'b1, data: 8'h41, gap: 71};
    vecs[1] = '{rs: 1'b0, data: 8'h01, gap: 231};
    vecs[2] = '{rs: 1'b1, data: 8'h01, gap: 71};
    vecs[3] = '{rs: 1'b0, data: 8'h02, gap: 231};
    vecs[4] = '{rs: 1'b0, data: 8'h03, gap: 231};
    vecs[5] = '{rs: 1'b0, data: 8'h04, gap: 71};
    vecs[6] = '{rs: 1'b0, data: 8'h00, gap: 71};
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_e", e, 0);
    chk("rst_rs", rs, 0);
    chk("rst_rw", rw, 0);
    chk("rst_db", db, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_busy", busy, 1);
    chk("rst_init_done", init_done, 0);
    do_init(1'b0);
    for (int i = 0; i < 7; i++) begin
      clear_pulses();
      send(vecs[i].rs, vecs[i].data, acc);
      chk($sformatf("v%0d_rs", i), rs, vecs[i].rs);
      chk($sformatf("v%0d_db", i), db, vecs[i].data);
      chk($sformatf("v%0d_busy", i), busy, 1);
      wait_rdy($sformatf("v%0d", i), r);
      chk($sformatf("v%0d_gap", i), r - acc, vecs[i].gap);
      chk($sformatf("v%0d_e_rise", i), e_rise - acc, 4);
      chk($sformatf("v%0d_e_fall", i), e_fall - acc, 29);
      chk($sformatf("v%0d_pulses", i), p_data.size(), 1);
      if (p_w.size() > 0) chk($sformatf("v%0d_width", i), p_w[0], 25);
      chk($sformatf("v%0d_rw", i), rw, 0);
      chk($sformatf("v%0d_db_kept", i), db, vecs[i].data);
    end
    clear_pulses();
    @(negedge clk);
    req_valid = 1'b1;
    req_rs = 1'b1;
    req_data = 8'h41;
    wait_rdy("b2b1", a1);
    @(negedge clk);
    req_data = 8'h42;
    wait_rdy("b2b2", a2);
    @(negedge clk);
    req_data = 8'h43;
    wait_rdy("b2b3", a3);
    @(negedge clk);
    req_valid = 1'b0;
    wait_rdy("b2b_end", r);
    chk("b2b_interval_1", a2 - a1, 71);
    chk("b2b_interval_2", a3 - a2, 71);
    chk("b2b_pulses", p_data.size(), 3);
    for (int i = 0; i < 3 && i < p_data.size(); i++) chk($sformatf("b2b_data_%0d", i), p_data[i], 8'h41 + i);
    clear_pulses();
    send(1'b1, 8'h5A, acc);
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      req_valid = 1'($urandom_range(0, 1));
      req_rs = 1'($urandom_range(0, 1));
      req_data = 8'($urandom);
      @(negedge clk);
      if (db != 8'h5A || rs != 1'b1) bad++;
    end
    req_valid = 1'b0;
    wait_rdy("toggle", r);
    chk("toggle_bus_changes", bad, 0);
    chk("toggle_gap", r - acc, 71);
    chk("toggle_pulses", p_data.size(), 1);
    send(1'b1, 8'h77, acc);
    r = 0;
    while (!e && r < 100) begin
      @(negedge clk);
      r++;
    end
    chk("abort_e_high_seen", e, 1);
    #2 reset = 1'b0;
    req_valid = 1'b1;
    req_rs = 1'b1;
    req_data = 8'h55;
    #1;
    chk("abort_e_async", e, 0);
    chk("abort_ready_async", req_ready, 0);
    chk("abort_busy_async", busy, 1);
    chk("abort_init_done", init_done, 0);
    repeat (3) @(negedge clk);
    do_init(1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
